instruction_fetch: RTL and testbench

Fetch stage that feeds the 8-bit control unit. It owns the program counter and issues a request/acknowledge read to instruction memory. It latches the returned byte into an instruction register and presents it on `inst` for exactly one execute cycle, or longer while stalled. When no instruction is being executed, `inst` is forced to 8'h00 (NOP), so the downstream decoder asserts no register or ALU controls.

---
 rtl/instruction_fetch.sv | 94 +++++++++
 tb/tb_instruction_fetch.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage for the 8-bit control unit: owns the program counter, reads instruction
// memory over a req/ack handshake and presents one instruction per execute slot.
module instruction_fetch #(
    parameter int unsigned           PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0]   RESET_PC = {PC_WIDTH{1'b0}}
) (
    input  logic                clk,
    input  logic                rstN,
    input  logic                stall,
    input  logic                jumpEn,
    input  logic [PC_WIDTH-1:0] jumpAddr,
    output logic                memReq,
    output logic [PC_WIDTH-1:0] memAddr,
    input  logic                memAck,
    input  logic [7:0]          memData,
    output logic [7:0]          inst,
    output logic                instValid,
    output logic [PC_WIDTH-1:0] pc
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

    state_t              state_q;
    logic [PC_WIDTH-1:0] fetch_pc_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic [7:0]          ir_q;
    logic [PC_WIDTH-1:0] fetch_pc_inc_s;

    // Increment wraps silently modulo 2^PC_WIDTH.
    assign fetch_pc_inc_s = fetch_pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};

    // Fetch sequencer: state, fetch address, instruction register and executing PC.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            pc_q       <= RESET_PC;
            ir_q       <= 8'h00;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= FETCH;
                end
                FETCH: begin
                    if (memAck) begin
                        ir_q       <= memData;
                        pc_q       <= fetch_pc_q;
                        fetch_pc_q <= fetch_pc_inc_s;
                        state_q    <= EXEC;
                    end else begin
                        state_q    <= FETCH;
                    end
                end
                EXEC: begin
                    if (stall) begin
                        state_q <= EXEC;
                    end else if (jumpEn) begin
                        fetch_pc_q <= jumpAddr;
                        state_q    <= FETCH;
                    end else begin
                        state_q    <= FETCH;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Outputs depend only on registered state, so no input reaches them combinationally.
    always_comb begin
        memReq    = 1'b0;
        instValid = 1'b0;
        inst      = 8'h00;
        if (state_q == FETCH) begin
            memReq = 1'b1;
        end else if (state_q == EXEC) begin
            instValid = 1'b1;
            inst      = ir_q;
        end else begin
            memReq    = 1'b0;
            instValid = 1'b0;
        end
    end

    assign memAddr = fetch_pc_q;
    assign pc      = pc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch.
module tb_instruction_fetch;

    logic       clk;
    logic       rstN;
    logic       stall;
    logic       jumpEn;
    logic [7:0] jumpAddr;
    logic       memReq;
    logic [7:0] memAddr;
    logic       memAck;
    logic [7:0] memData;
    logic [7:0] inst;
    logic       instValid;
    logic [7:0] pc;

    logic       auto_ack;
    logic       man_ack;
    logic [7:0] mem [0:255];

    int checks;
    int errors;

    instruction_fetch #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut (
        .clk      (clk),
        .rstN     (rstN),
        .stall    (stall),
        .jumpEn   (jumpEn),
        .jumpAddr (jumpAddr),
        .memReq   (memReq),
        .memAddr  (memAddr),
        .memAck   (memAck),
        .memData  (memData),
        .inst     (inst),
        .instValid(instValid),
        .pc       (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign memData = mem[memAddr];
    assign memAck  = auto_ack ? memReq : man_ack;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rstN = 1'b0;
        #3;
        stall = 1'b0; jumpEn = 1'b0; man_ack = 1'b0; auto_ack = 1'b0;
        step();
        rstN = 1'b1;
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        stall = 1'($urandom); jumpEn = 1'($urandom);
        jumpAddr = 8'($urandom); man_ack = 1'($urandom); auto_ack = 1'b0;
        #12;
        checks++; if (memReq !== 1'b0) begin errors++; $display("FAIL reset_memReq got %0b want 0", memReq); end
        checks++; if (instValid !== 1'b0) begin errors++; $display("FAIL reset_instValid got %0b want 0", instValid); end
        checks++; if (inst !== 8'h00) begin errors++; $display("FAIL reset_inst got %h want 00", inst); end
        checks++; if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc got %h want 00", pc); end
        checks++; if (memAddr !== 8'h00) begin errors++; $display("FAIL reset_memAddr got %h want 00", memAddr); end
        step();
        stall = 1'b0; jumpEn = 1'b0; man_ack = 1'b0;
        rstN = 1'b1;
        checks++; if (memReq !== 1'b0) begin errors++; $display("FAIL idle_memReq got %0b want 0", memReq); end
        step();
        checks++; if (memReq !== 1'b1 || memAddr !== 8'h00)
            begin errors++; $display("FAIL first_req got req=%0b addr=%h want req=1 addr=00", memReq, memAddr); end
    endtask

    task automatic test_sequential();
        logic [7:0] exp_inst [4];
        exp_inst[0] = 8'h08; exp_inst[1] = 8'h49; exp_inst[2] = 8'h1A; exp_inst[3] = 8'h38;
        auto_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (instValid !== 1'b1 || inst !== exp_inst[i] || pc !== 8'(i))
                begin errors++; $display("FAIL seq_exec%0d got v=%0b inst=%h pc=%h want v=1 inst=%h pc=%h", i, instValid, inst, pc, exp_inst[i], 8'(i)); end
            step();
            checks++; if (instValid !== 1'b0 || inst !== 8'h00 || memReq !== 1'b1 || memAddr !== 8'(i+1))
                begin errors++; $display("FAIL seq_gap%0d got v=%0b inst=%h req=%0b addr=%h want v=0 inst=00 req=1 addr=%h", i, instValid, inst, memReq, memAddr, 8'(i+1)); end
        end
        auto_ack = 1'b0;
    endtask

    task automatic test_wait_states();
        apply_reset();
        step();
        for (int c = 0; c < 4; c++) begin
            checks++; if (memReq !== 1'b1 || memAddr !== 8'h00 || instValid !== 1'b0)
                begin errors++; $display("FAIL wait_cyc%0d got req=%0b addr=%h v=%0b want req=1 addr=00 v=0", c, memReq, memAddr, instValid); end
            if (c == 3) man_ack = 1'b1;
            else step();
        end
        step();
        man_ack = 1'b0;
        checks++; if (instValid !== 1'b1 || inst !== 8'h08 || pc !== 8'h00)
            begin errors++; $display("FAIL wait_valid got v=%0b inst=%h pc=%h want v=1 inst=08 pc=00", instValid, inst, pc); end
    endtask

    task automatic test_stall();
        step();
        auto_ack = 1'b1;
        step();
        stall = 1'b1;
        for (int c = 0; c < 4; c++) begin
            checks++; if (instValid !== 1'b1 || inst !== 8'h49 || pc !== 8'h01 || memReq !== 1'b0)
                begin errors++; $display("FAIL stall_hold%0d got v=%0b inst=%h pc=%h req=%0b want v=1 inst=49 pc=01 req=0", c, instValid, inst, pc, memReq); end
            if (c == 3) stall = 1'b0;
            step();
        end
        checks++; if (memReq !== 1'b1 || memAddr !== 8'h02 || inst !== 8'h00)
            begin errors++; $display("FAIL stall_next got req=%0b addr=%h inst=%h want req=1 addr=02 inst=00", memReq, memAddr, inst); end
        step();
    endtask

    task automatic test_jump_wrap();
        stall = 1'b1; jumpEn = 1'b1; jumpAddr = 8'hFF;
        step();
        checks++; if (instValid !== 1'b1 || inst !== 8'h1A)
            begin errors++; $display("FAIL jump_stall_hold got v=%0b inst=%h want v=1 inst=1A", instValid, inst); end
        stall = 1'b0; jumpEn = 1'b0;
        step();
        checks++; if (memReq !== 1'b1 || memAddr !== 8'h03)
            begin errors++; $display("FAIL jump_ignored got req=%0b addr=%h want req=1 addr=03", memReq, memAddr); end
        step();
        checks++; if (inst !== 8'h38 || pc !== 8'h03)
            begin errors++; $display("FAIL pre_jump_exec got inst=%h pc=%h want 38/03", inst, pc); end
        jumpEn = 1'b1; jumpAddr = 8'hFF;
        step();
        jumpEn = 1'b0;
        checks++; if (memReq !== 1'b1 || memAddr !== 8'hFF)
            begin errors++; $display("FAIL jump_target got req=%0b addr=%h want req=1 addr=FF", memReq, memAddr); end
        step();
        checks++; if (instValid !== 1'b1 || inst !== 8'hC3 || pc !== 8'hFF)
            begin errors++; $display("FAIL jump_exec got v=%0b inst=%h pc=%h want v=1 inst=C3 pc=FF", instValid, inst, pc); end
        step();
        checks++; if (memReq !== 1'b1 || memAddr !== 8'h00)
            begin errors++; $display("FAIL wrap_addr got req=%0b addr=%h want req=1 addr=00", memReq, memAddr); end
        step();
        checks++; if (inst !== 8'h08 || pc !== 8'h00)
            begin errors++; $display("FAIL wrap_exec got inst=%h pc=%h want 08/00", inst, pc); end
    endtask

    task automatic test_reset_mid_exec();
        #2;
        rstN = 1'b0;
        #1;
        checks++; if (instValid !== 1'b0 || inst !== 8'h00)
            begin errors++; $display("FAIL rst_exec got v=%0b inst=%h want v=0 inst=00", instValid, inst); end
        auto_ack = 1'b0;
        step();
        rstN = 1'b1;
        step();
    endtask

    task automatic test_reset_mid_fetch();
        auto_ack = 1'b1;
        step();
        auto_ack = 1'b0;
        jumpEn = 1'b1; jumpAddr = 8'h05;
        step();
        jumpEn = 1'b0;
        checks++; if (memReq !== 1'b1 || memAddr !== 8'h05)
            begin errors++; $display("FAIL pre_rst_fetch got req=%0b addr=%h want req=1 addr=05", memReq, memAddr); end
        man_ack = 1'b1;
        #2;
        rstN = 1'b0;
        #1;
        checks++; if (memReq !== 1'b0 || memAddr !== 8'h00)
            begin errors++; $display("FAIL rst_fetch_drop got req=%0b addr=%h want req=0 addr=00", memReq, memAddr); end
        step();
        man_ack = 1'b0;
        rstN = 1'b1;
        checks++; if (instValid !== 1'b0 || pc !== 8'h00)
            begin errors++; $display("FAIL rst_fetch_discard got v=%0b pc=%h want v=0 pc=00", instValid, pc); end
        step();
        checks++; if (memReq !== 1'b1 || memAddr !== 8'h00 || instValid !== 1'b0)
            begin errors++; $display("FAIL rst_fetch_restart got req=%0b addr=%h v=%0b want req=1 addr=00 v=0", memReq, memAddr, instValid); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        mem[0] = 8'h08; mem[1] = 8'h49; mem[2] = 8'h1A; mem[3] = 8'h38;
        mem[5] = 8'h77; mem[255] = 8'hC3;
        rstN = 1'b0; stall = 1'b0; jumpEn = 1'b0; jumpAddr = 8'h00;
        auto_ack = 1'b0; man_ack = 1'b0;

        test_reset();
        test_sequential();
        test_wait_states();
        test_stall();
        test_jump_wrap();
        test_reset_mid_exec();
        test_reset_mid_fetch();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
